// File: rtl/guess_display_seq.sv
// Registered seven-segment / LED driver for the N-digit A/B guessing game.
// Owns the blink divider and a timed per-digit result reveal with A/B tallies.
module guess_display_seq #(
    parameter int N_DIGITS      = 4,
    parameter int MAX_CHANCES   = 5,
    parameter int LED_W         = 10,
    parameter int BLINK_DIV     = 25_000_000,
    parameter int REVEAL_CYCLES = 12_500_000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [2:0]                       mode,
    input  logic [$clog2(N_DIGITS)-1:0]      cursor,
    input  logic [4*N_DIGITS-1:0]            target,
    input  logic [4*N_DIGITS-1:0]            guess,
    input  logic [3:0]                       candidate,
    input  logic                             sw_valid,
    input  logic [N_DIGITS-1:0]              is_random,
    input  logic [$clog2(MAX_CHANCES+1)-1:0] chances,
    input  logic                             result_start,
    output logic [7*N_DIGITS-1:0]            hex_seg,
    output logic [LED_W-1:0]                 ledr,
    output logic [3:0]                       a_count,
    output logic [3:0]                       b_count,
    output logic                             reveal_done,
    output logic                             blink
);

    localparam int CW = $clog2(N_DIGITS);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int TW = $clog2(REVEAL_CYCLES + 1);

    localparam logic [3:0] CH_A  = 4'hA;
    localparam logic [3:0] CH_B  = 4'hB;
    localparam logic [3:0] CH_US = 4'hC;
    localparam logic [3:0] CH_L  = 4'hD;
    localparam logic [3:0] CH_E  = 4'hE;
    localparam logic [3:0] CH_BL = 4'hF;

    localparam logic [2:0] M_SET    = 3'd1;
    localparam logic [2:0] M_GUESS  = 3'd2;
    localparam logic [2:0] M_RESULT = 3'd3;
    localparam logic [2:0] M_WIN    = 3'd4;
    localparam logic [2:0] M_LOSE   = 3'd5;

    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] hex_decoder(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h77;
            4'hD:    s = 7'h47;
            4'hE:    s = 7'h06;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {R_IDLE, R_RUN, R_DONE} r_state_t;

    r_state_t              state_q, state_d;
    logic [BW-1:0]         blink_cnt;
    logic [CW-1:0]         ptr_q, ptr_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [4*N_DIGITS-1:0] g_snap_q, g_snap_d;
    logic [4*N_DIGITS-1:0] t_snap_q, t_snap_d;
    logic [N_DIGITS-1:0]   rev_q, rev_d;
    logic [N_DIGITS-1:0]   isa_q, isa_d;
    logic [N_DIGITS-1:0]   isb_q, isb_d;
    logic [3:0]            a_q, a_d, b_q, b_d;
    logic                  done_q, done_d;
    logic [3:0]            g_cur;
    logic                  hit_a, hit_b;
    logic [4*N_DIGITS-1:0] ch_d;
    logic [7*N_DIGITS-1:0] seg_d;
    logic [LED_W-1:0]      led_d;
    int                    k;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // A beats B: B only counts a match at some other target position.
    always_comb begin
        g_cur = g_snap_q[4*ptr_q +: 4];
        hit_a = (g_cur == t_snap_q[4*ptr_q +: 4]);
        hit_b = 1'b0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j != int'(ptr_q) && t_snap_q[4*j +: 4] == g_cur)
                hit_b = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        tmr_d    = tmr_q;
        g_snap_d = g_snap_q;
        t_snap_d = t_snap_q;
        rev_d    = rev_q;
        isa_d    = isa_q;
        isb_d    = isb_q;
        a_d      = a_q;
        b_d      = b_q;
        done_d   = done_q;
        if (mode != M_RESULT) begin
            state_d = R_IDLE;
            rev_d   = '0;
            isa_d   = '0;
            isb_d   = '0;
            a_d     = '0;
            b_d     = '0;
            done_d  = 1'b0;
        end else if (result_start) begin
            state_d  = R_RUN;
            ptr_d    = CW'(N_DIGITS - 1);
            tmr_d    = '0;
            g_snap_d = guess;
            t_snap_d = target;
            rev_d    = '0;
            isa_d    = '0;
            isb_d    = '0;
            a_d      = '0;
            b_d      = '0;
            done_d   = 1'b0;
        end else if (state_q == R_RUN) begin
            if (tmr_q == TW'(REVEAL_CYCLES - 1)) begin
                tmr_d        = '0;
                rev_d[ptr_q] = 1'b1;
                isa_d[ptr_q] = hit_a;
                isb_d[ptr_q] = !hit_a && hit_b;
                a_d          = a_q + 4'(hit_a);
                b_d          = b_q + 4'(!hit_a && hit_b);
                if (ptr_q == '0)
                    state_d = R_DONE;
                else
                    ptr_d = ptr_q - CW'(1);
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end else if (state_q == R_DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= R_IDLE;
            ptr_q    <= '0;
            tmr_q    <= '0;
            g_snap_q <= '0;
            t_snap_q <= '0;
            rev_q    <= '0;
            isa_q    <= '0;
            isb_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            tmr_q    <= tmr_d;
            g_snap_q <= g_snap_d;
            t_snap_q <= t_snap_d;
            rev_q    <= rev_d;
            isa_q    <= isa_d;
            isb_q    <= isb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            done_q   <= done_d;
        end
    end

    // Fixed banners occupy the leftmost four digits; lead[15:12] is leftmost.
    always_comb begin : disp
        logic [15:0] lead;
        lead = {4'h1, CH_A, 4'h2, CH_B};
        case (mode)
            M_WIN:   lead = {4'(N_DIGITS), CH_A, 4'h0, CH_B};
            M_LOSE:  lead = {CH_L, 4'h0, 4'h5, CH_E};
            default: ;
        endcase
        ch_d = {N_DIGITS{CH_BL}};
        for (int i = 0; i < N_DIGITS; i++) begin
            case (mode)
                M_SET: begin
                    unique case (1'b1)
                        (i > int'(cursor)):
                            ch_d[4*i +: 4] = is_random[i] ? CH_US : target[4*i +: 4];
                        (i == int'(cursor)):
                            ch_d[4*i +: 4] = sw_valid ? (blink ? candidate : CH_BL) : CH_US;
                        default:
                            ch_d[4*i +: 4] = CH_US;
                    endcase
                end
                M_GUESS: begin
                    unique case (1'b1)
                        (i > int'(cursor)):
                            ch_d[4*i +: 4] = guess[4*i +: 4];
                        (i == int'(cursor)):
                            ch_d[4*i +: 4] = blink ? (sw_valid ? candidate : CH_US) : CH_BL;
                        default:
                            ch_d[4*i +: 4] = CH_US;
                    endcase
                end
                M_RESULT: ch_d[4*i +: 4] = guess[4*i +: 4];
                default: begin
                    if (i >= N_DIGITS - 4)
                        ch_d[4*i +: 4] = lead[4*(i-(N_DIGITS-4)) +: 4];
                end
            endcase
        end
    end

    always_comb begin
        seg_d = '0;
        for (int i = 0; i < N_DIGITS; i++)
            seg_d[7*i +: 7] = hex_decoder(ch_d[4*i +: 4]);
    end

    always_comb begin
        led_d = '0;
        k = (int'(chances) > MAX_CHANCES) ? MAX_CHANCES : int'(chances);
        case (mode)
            M_SET: ;
            M_GUESS: begin
                for (int b = 0; b < MAX_CHANCES; b++) begin
                    if (b + 1 < k)
                        led_d[b] = 1'b1;
                    else if (b + 1 == k)
                        led_d[b] = blink;
                end
            end
            M_RESULT: begin
                for (int b = 0; b < MAX_CHANCES; b++)
                    led_d[b] = (b < k);
                for (int i = 0; i < N_DIGITS; i++)
                    led_d[LED_W-N_DIGITS+i] =
                        rev_q[i] & (isa_q[i] | (isb_q[i] & blink));
            end
            default: led_d = {LED_W{blink}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex_seg <= {N_DIGITS{7'h7F}};
            ledr    <= '0;
        end else begin
            hex_seg <= seg_d;
            ledr    <= led_d;
        end
    end

    assign a_count     = a_q;
    assign b_count     = b_q;
    assign reveal_done = done_q;

endmodule

// File: tb/tb_guess_display_seq.sv
// Directed bench for guess_display_seq: 4-digit instance for all modes and
// the reveal sequence, 6-digit instance for the WIN banner.
module tb_guess_display_seq;

    localparam int BD = 4;

    localparam logic [6:0] S0  = 7'h40;
    localparam logic [6:0] S1  = 7'h79;
    localparam logic [6:0] S2  = 7'h24;
    localparam logic [6:0] S3  = 7'h30;
    localparam logic [6:0] S4  = 7'h19;
    localparam logic [6:0] S5  = 7'h12;
    localparam logic [6:0] S6  = 7'h02;
    localparam logic [6:0] S7  = 7'h78;
    localparam logic [6:0] S9  = 7'h10;
    localparam logic [6:0] SA  = 7'h08;
    localparam logic [6:0] SB  = 7'h03;
    localparam logic [6:0] SUS = 7'h77;
    localparam logic [6:0] SL  = 7'h47;
    localparam logic [6:0] SE  = 7'h06;
    localparam logic [6:0] SBL = 7'h7F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  mode;
    logic [1:0]  cursor;
    logic [15:0] target, guess;
    logic [3:0]  candidate;
    logic        sw_valid;
    logic [3:0]  is_random;
    logic [2:0]  chances;
    logic        result_start;
    logic [27:0] hex4;
    logic [9:0]  ledr4;
    logic [3:0]  a4, b4;
    logic        done4, blink4;

    logic [2:0]  mode6;
    logic [2:0]  cursor6;
    logic [23:0] target6, guess6;
    logic [3:0]  candidate6;
    logic        sw_valid6;
    logic [5:0]  is_random6;
    logic [2:0]  chances6;
    logic        result_start6;
    logic [41:0] hex6;
    logic [9:0]  ledr6;
    logic [3:0]  a6, b6;
    logic        done6, blink6;

    guess_display_seq #(
        .N_DIGITS(4), .MAX_CHANCES(5), .LED_W(10),
        .BLINK_DIV(BD), .REVEAL_CYCLES(3)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .cursor(cursor),
        .target(target), .guess(guess), .candidate(candidate),
        .sw_valid(sw_valid), .is_random(is_random), .chances(chances),
        .result_start(result_start), .hex_seg(hex4), .ledr(ledr4),
        .a_count(a4), .b_count(b4), .reveal_done(done4), .blink(blink4)
    );

    guess_display_seq #(
        .N_DIGITS(6), .MAX_CHANCES(4), .LED_W(10),
        .BLINK_DIV(BD), .REVEAL_CYCLES(3)
    ) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode6), .cursor(cursor6),
        .target(target6), .guess(guess6), .candidate(candidate6),
        .sw_valid(sw_valid6), .is_random(is_random6), .chances(chances6),
        .result_start(result_start6), .hex_seg(hex6), .ledr(ledr6),
        .a_count(a6), .b_count(b6), .reveal_done(done6), .blink(blink6)
    );

    int cyc;
    int n_cmp = 0;
    int n_bad = 0;

    // Edges since reset release; drives the bench's own blink expectation.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic eb_at(int n);
        return ((n / BD) % 2) == 1;
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 3'd1; cursor = 2'd0; target = '0; guess = '0;
        candidate = 4'd0; sw_valid = 1'b0; is_random = '0;
        chances = 3'd0; result_start = 1'b0;
        mode6 = 3'd0; cursor6 = '0; target6 = '0; guess6 = '0;
        candidate6 = '0; sw_valid6 = 1'b0; is_random6 = '0;
        chances6 = '0; result_start6 = 1'b0;
        step(3);
        n_cmp++;
        if (blink4 !== 1'b0) begin n_bad++; $display("FAIL reset_blink got %b want 0", blink4); end
        n_cmp++;
        if (hex4 !== {4{SBL}}) begin n_bad++; $display("FAIL reset_hex got %h want %h", hex4, {4{SBL}}); end
        n_cmp++;
        if (ledr4 !== 10'd0) begin n_bad++; $display("FAIL reset_ledr got %b want 0", ledr4); end
        n_cmp++;
        if (a4 !== 4'd0 || b4 !== 4'd0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d want 0/0", a4, b4); end
        n_cmp++;
        if (done4 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done4); end
        n_cmp++;
        if (hex6 !== {6{SBL}}) begin n_bad++; $display("FAIL reset_hex6 got %h want %h", hex6, {6{SBL}}); end
    endtask

    task automatic test_blink();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            n_cmp++;
            if (blink4 !== eb_at(cyc)) begin n_bad++; $display("FAIL blink_phase cyc=%0d got %b want %b", cyc, blink4, eb_at(cyc)); end
            n_cmp++;
            if (ledr4 !== 10'd0) begin n_bad++; $display("FAIL set_ledr got %b want 0", ledr4); end
        end
    endtask

    task automatic test_set();
        logic [27:0] exp;
        mode = 3'd1; cursor = 2'd1; target = 16'h7300;
        is_random = 4'b0100; sw_valid = 1'b1; candidate = 4'd5;
        step(1);
        for (int i = 0; i < 6; i++) begin
            exp = {S7, SUS, (eb_at(cyc - 1) ? S5 : SBL), SUS};
            n_cmp++;
            if (hex4 !== exp) begin n_bad++; $display("FAIL set_digits got %h want %h", hex4, exp); end
            step(1);
        end
        sw_valid = 1'b0;
        step(1);
        exp = {S7, SUS, SUS, SUS};
        n_cmp++;
        if (hex4 !== exp) begin n_bad++; $display("FAIL set_invalid got %h want %h", hex4, exp); end
    endtask

    task automatic test_guess();
        logic [27:0] exph;
        logic [9:0]  expl;
        logic        eb;
        mode = 3'd2; cursor = 2'd0; guess = 16'h1325;
        sw_valid = 1'b0; chances = 3'd3;
        step(1);
        for (int i = 0; i < 5; i++) begin
            eb = eb_at(cyc - 1);
            expl = {7'b0, eb, 2'b11};
            exph = {S1, S3, S2, (eb ? SUS : SBL)};
            n_cmp++;
            if (ledr4 !== expl) begin n_bad++; $display("FAIL guess_bar3 got %b want %b", ledr4, expl); end
            n_cmp++;
            if (hex4 !== exph) begin n_bad++; $display("FAIL guess_digits got %h want %h", hex4, exph); end
            step(1);
        end
        sw_valid = 1'b1; candidate = 4'd9;
        step(1);
        for (int i = 0; i < 4; i++) begin
            eb = eb_at(cyc - 1);
            exph = {S1, S3, S2, (eb ? S9 : SBL)};
            n_cmp++;
            if (hex4 !== exph) begin n_bad++; $display("FAIL guess_cand got %h want %h", hex4, exph); end
            step(1);
        end
        chances = 3'd7;
        step(1);
        for (int i = 0; i < 4; i++) begin
            eb = eb_at(cyc - 1);
            expl = {5'b0, eb, 4'b1111};
            n_cmp++;
            if (ledr4 !== expl) begin n_bad++; $display("FAIL guess_bar_sat got %b want %b", ledr4, expl); end
            step(1);
        end
        chances = 3'd0;
        step(1);
        n_cmp++;
        if (ledr4 !== 10'd0) begin n_bad++; $display("FAIL guess_bar0 got %b want 0", ledr4); end
        chances = 3'd1;
        step(1);
        for (int i = 0; i < 4; i++) begin
            eb = eb_at(cyc - 1);
            expl = {9'b0, eb};
            n_cmp++;
            if (ledr4 !== expl) begin n_bad++; $display("FAIL guess_bar1 got %b want %b", ledr4, expl); end
            step(1);
        end
    endtask

    task automatic test_modes();
        logic [27:0] exph;
        logic        eb;
        mode = 3'd0;
        step(1);
        for (int i = 0; i < 4; i++) begin
            eb = eb_at(cyc - 1);
            exph = {S1, SA, S2, SB};
            n_cmp++;
            if (hex4 !== exph) begin n_bad++; $display("FAIL idle_digits got %h want %h", hex4, exph); end
            n_cmp++;
            if (ledr4 !== {10{eb}}) begin n_bad++; $display("FAIL idle_ledr got %b want %b", ledr4, {10{eb}}); end
            step(1);
        end
        mode = 3'd5;
        step(1);
        exph = {SL, S0, S5, SE};
        n_cmp++;
        if (hex4 !== exph) begin n_bad++; $display("FAIL lose_digits got %h want %h", hex4, exph); end
        n_cmp++;
        if (ledr4 !== {10{eb_at(cyc - 1)}}) begin n_bad++; $display("FAIL lose_ledr got %b", ledr4); end
        mode = 3'd4;
        step(1);
        exph = {S4, SA, S0, SB};
        n_cmp++;
        if (hex4 !== exph) begin n_bad++; $display("FAIL win4_digits got %h want %h", hex4, exph); end
        mode = 3'd7;
        step(1);
        exph = {S1, SA, S2, SB};
        n_cmp++;
        if (hex4 !== exph) begin n_bad++; $display("FAIL mode7_digits got %h want %h", hex4, exph); end
    endtask

    task automatic test_win6();
        logic [41:0] exph;
        logic        eb;
        mode6 = 3'd4;
        step(1);
        exph = {S6, SA, S0, SB, SBL, SBL};
        for (int i = 0; i < 5; i++) begin
            eb = eb_at(cyc - 1);
            n_cmp++;
            if (hex6 !== exph) begin n_bad++; $display("FAIL win6_digits got %h want %h", hex6, exph); end
            n_cmp++;
            if (ledr6 !== {10{eb}}) begin n_bad++; $display("FAIL win6_ledr got %b want %b", ledr6, {10{eb}}); end
            n_cmp++;
            if (blink6 !== eb_at(cyc)) begin n_bad++; $display("FAIL win6_blink got %b want %b", blink6, eb_at(cyc)); end
            step(1);
        end
        n_cmp++;
        if (a6 !== 4'd0 || b6 !== 4'd0 || done6 !== 1'b0) begin n_bad++; $display("FAIL win6_counts got %0d/%0d/%b want 0/0/0", a6, b6, done6); end
    endtask

    task automatic test_result();
        logic [3:0] ea, eb4;
        logic       ed, eb;
        logic [9:0] el;
        mode = 3'd3; target = 16'h1234; guess = 16'h1325;
        chances = 3'd3; result_start = 1'b1;
        step(1);
        result_start = 1'b0;
        n_cmp++;
        if (hex4 !== {S1, S3, S2, S5}) begin n_bad++; $display("FAIL result_digits got %h", hex4); end
        for (int t = 0; t <= 15; t++) begin
            if (t > 0) step(1);
            eb  = eb_at(cyc - 1);
            ea  = (t >= 3) ? 4'd1 : 4'd0;
            eb4 = (t >= 9) ? 4'd2 : (t >= 6) ? 4'd1 : 4'd0;
            ed  = (t >= 13);
            el  = {(t >= 4), (t >= 7) & eb, (t >= 10) & eb, 1'b0, 3'b000, 3'b111};
            n_cmp++;
            if (a4 !== ea) begin n_bad++; $display("FAIL reveal_a t=%0d got %0d want %0d", t, a4, ea); end
            n_cmp++;
            if (b4 !== eb4) begin n_bad++; $display("FAIL reveal_b t=%0d got %0d want %0d", t, b4, eb4); end
            n_cmp++;
            if (done4 !== ed) begin n_bad++; $display("FAIL reveal_done t=%0d got %b want %b", t, done4, ed); end
            n_cmp++;
            if (ledr4 !== el) begin n_bad++; $display("FAIL reveal_ledr t=%0d got %b want %b", t, ledr4, el); end
        end
    endtask

    task automatic test_abort();
        result_start = 1'b1;
        step(1);
        result_start = 1'b0;
        n_cmp++;
        if (a4 !== 4'd0 || b4 !== 4'd0 || done4 !== 1'b0) begin n_bad++; $display("FAIL restart_clear got %0d/%0d/%b want 0/0/0", a4, b4, done4); end
        step(3);
        n_cmp++;
        if (a4 !== 4'd1) begin n_bad++; $display("FAIL restart_a got %0d want 1", a4); end
        step(1);
        mode = 3'd2;
        step(1);
        n_cmp++;
        if (a4 !== 4'd0 || b4 !== 4'd0 || done4 !== 1'b0) begin n_bad++; $display("FAIL abort_clear got %0d/%0d/%b want 0/0/0", a4, b4, done4); end
        step(1);
        n_cmp++;
        if (ledr4[9:6] !== 4'b0000) begin n_bad++; $display("FAIL abort_fb_guess got %b want 0000", ledr4[9:6]); end
        mode = 3'd3;
        step(2);
        n_cmp++;
        if (ledr4[9:6] !== 4'b0000) begin n_bad++; $display("FAIL abort_fb_result got %b want 0000", ledr4[9:6]); end
        n_cmp++;
        if (a4 !== 4'd0 || done4 !== 1'b0) begin n_bad++; $display("FAIL abort_idle got %0d/%b want 0/0", a4, done4); end
    endtask

    task automatic test_start_ignored();
        mode = 3'd2; result_start = 1'b1;
        step(1);
        result_start = 1'b0; mode = 3'd3;
        step(5);
        n_cmp++;
        if (a4 !== 4'd0) begin n_bad++; $display("FAIL start_ignored_a got %0d want 0", a4); end
        n_cmp++;
        if (ledr4[9] !== 1'b0) begin n_bad++; $display("FAIL start_ignored_led got %b want 0", ledr4[9]); end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_set();
        test_guess();
        test_modes();
        test_win6();
        test_result();
        test_abort();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
